// File: rtl/game_status_pkg.sv
// Shared encodings and BCD helpers for the game-status tracker.
// Pure declarations: no state, no latency, no flow control.
package game_status_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PLAY = 2'd1;
  localparam logic [1:0] WON  = 2'd2;
  localparam logic [1:0] LOST = 2'd3;

  localparam logic GAME_WON = 1'b0;
  localparam logic GAME_LSE = 1'b1;

  localparam int BCD_W = 4;

  typedef logic [3*BCD_W-1:0] bcd3_t;

  // Elaboration-time conversion of an integer parameter (0..999) to BCD.
  function automatic bcd3_t to_bcd3(input int v);
    logic [BCD_W-1:0] d2, d1, d0;
    d2 = BCD_W'(v / 100);
    d1 = BCD_W'((v / 10) % 10);
    d0 = BCD_W'(v % 10);
    return {d2, d1, d0};
  endfunction

  // Decimal increment that saturates at 999.
  function automatic bcd3_t bcd3_inc(input bcd3_t v);
    bcd3_t r;
    r = v;
    if (v != 12'h999) begin
      if (v[3:0] != 4'd9) begin
        r[3:0] = v[3:0] + 4'd1;
      end else begin
        r[3:0] = 4'd0;
        if (v[7:4] != 4'd9) begin
          r[7:4] = v[7:4] + 4'd1;
        end else begin
          r[7:4]  = 4'd0;
          r[11:8] = v[11:8] + 4'd1;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/game_status_bcd_counter3.sv
// Three-digit BCD counter with sync clear, increment and saturation at 999.
// Value is registered (1 cycle); eq_next flags that the next value equals CMP_VAL.
module game_status_bcd_counter3
  import game_status_pkg::*;
#(
  parameter bcd3_t CMP_VAL = 12'h000
) (
  input  logic  vga_clk,
  input  logic  sys_rst_n,
  input  logic  clr,
  input  logic  inc,
  output bcd3_t value,
  output logic  eq_next
);

  bcd3_t nxt;

  always_comb begin
    nxt = value;
    if (clr) begin
      nxt = '0;
    end else if (inc) begin
      nxt = bcd3_inc(value);
    end
  end

  // Compare on the post-update value so end conditions fire in the same cycle.
  assign eq_next = (nxt == CMP_VAL);

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      value <= '0;
    end else begin
      value <= nxt;
    end
  end

endmodule

// File: rtl/game_status.sv
// Game lifecycle FSM with BCD score/time, lives and a one-cycle end pulse.
// All outputs registered, 1-cycle latency from input pulse; no backpressure.
module game_status
  import game_status_pkg::*;
#(
  parameter int CLK_FREQ   = 25_000_000,
  parameter int WIN_SCORE  = 100,
  parameter int LIVES      = 3,
  parameter int TIME_LIMIT = 999
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  input  logic        point,
  input  logic        hit,
  output logic [1:0]  game_state,
  output logic        game_result,
  output bcd3_t       score_bcd,
  output bcd3_t       time_bcd,
  output logic [1:0]  lives,
  output logic        end_pulse
);

  localparam int             PW        = $clog2(CLK_FREQ);
  localparam logic [PW-1:0]  PRESC_MAX = PW'(CLK_FREQ - 1);

  logic [PW-1:0] presc;
  logic          in_play;
  logic          enter_play;
  logic          tick;
  logic          score_win;
  logic          time_out;
  logic [1:0]    lives_nxt;
  logic          loss;
  logic          win;
  logic          game_end;

  assign in_play    = (game_state == PLAY);
  assign enter_play = start && !in_play;
  assign tick       = in_play && (presc == PRESC_MAX);
  assign lives_nxt  = (in_play && hit) ? lives - 2'd1 : lives;
  assign loss       = (lives_nxt == 2'd0) || time_out;
  assign win        = score_win;
  assign game_end   = in_play && (loss || win);

  game_status_bcd_counter3 #(
    .CMP_VAL (to_bcd3(WIN_SCORE))
  ) u_score (
    .vga_clk   (vga_clk),
    .sys_rst_n (sys_rst_n),
    .clr       (enter_play),
    .inc       (in_play && point),
    .value     (score_bcd),
    .eq_next   (score_win)
  );

  game_status_bcd_counter3 #(
    .CMP_VAL (to_bcd3(TIME_LIMIT))
  ) u_time (
    .vga_clk   (vga_clk),
    .sys_rst_n (sys_rst_n),
    .clr       (enter_play),
    .inc       (tick),
    .value     (time_bcd),
    .eq_next   (time_out)
  );

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      game_state  <= IDLE;
      game_result <= GAME_WON;
      lives       <= 2'd0;
      presc       <= '0;
      end_pulse   <= 1'b0;
    end else begin
      end_pulse <= game_end;
      if (enter_play) begin
        game_state <= PLAY;
        lives      <= 2'(LIVES);
        presc      <= '0;
      end else if (in_play) begin
        lives <= lives_nxt;
        presc <= tick ? '0 : presc + PW'(1);
        // Simultaneous win and loss resolves to a loss.
        if (game_end) begin
          game_state  <= loss ? LOST : WON;
          game_result <= loss ? GAME_LSE : GAME_WON;
        end
      end
    end
  end

endmodule

// File: tb/tb_game_status.sv
// Scoreboard bench for game_status: a behavioural model pushes expected outputs
// per driven cycle; each scenario task pops and compares after the clock edge.
module tb_game_status;

  localparam int CF = 10;
  localparam int WIN = 12;
  localparam int L = 3;
  localparam int TL = 5;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_WON  = 2'd2;
  localparam logic [1:0] S_LOST = 2'd3;

  logic vga_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic start = 1'b0, point = 1'b0, hit = 1'b0;
  logic start2 = 1'b0, point2 = 1'b0, hit2 = 1'b0;

  logic [1:0]  game_state, state2;
  logic        game_result, result2;
  logic [11:0] score_bcd, time_bcd, score2, time2;
  logic [1:0]  lives, lives2;
  logic        end_pulse, end2;

  always #5 vga_clk = ~vga_clk;

  game_status #(.CLK_FREQ(CF), .WIN_SCORE(WIN), .LIVES(L), .TIME_LIMIT(TL)) dut (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .start(start), .point(point), .hit(hit),
    .game_state(game_state), .game_result(game_result), .score_bcd(score_bcd),
    .time_bcd(time_bcd), .lives(lives), .end_pulse(end_pulse)
  );

  game_status #(.CLK_FREQ(CF), .WIN_SCORE(999), .LIVES(L), .TIME_LIMIT(999)) dut_sat (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .start(start2), .point(point2), .hit(hit2),
    .game_state(state2), .game_result(result2), .score_bcd(score2),
    .time_bcd(time2), .lives(lives2), .end_pulse(end2)
  );

  typedef logic [29:0] obs_t;
  obs_t        sb[$];
  logic [13:0] sb2[$];
  int n_chk = 0;
  int n_pass = 0;

  int m_state, m_res, m_score, m_time, m_lives, m_presc, m_end;

  function automatic logic [11:0] bcd(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  function automatic obs_t cur();
    return {game_state, game_result, score_bcd, time_bcd, lives, end_pulse};
  endfunction

  function automatic obs_t mexp();
    return {2'(m_state), 1'(m_res), bcd(m_score), bcd(m_time), 2'(m_lives), 1'(m_end)};
  endfunction

  task automatic model_reset();
    m_state = 0; m_res = 0; m_score = 0; m_time = 0;
    m_lives = 0; m_presc = 0; m_end = 0;
  endtask

  task automatic model_cycle(input logic s, input logic p, input logic h);
    int sc, lv, tm;
    bit ls, wn;
    if (m_state == 1) begin
      sc = p ? ((m_score < 999) ? m_score + 1 : 999) : m_score;
      lv = h ? m_lives - 1 : m_lives;
      tm = m_time;
      if (m_presc == CF - 1) begin
        m_presc = 0;
        tm = (tm < 999) ? tm + 1 : 999;
      end else begin
        m_presc = m_presc + 1;
      end
      ls = (lv == 0) || (tm == TL);
      wn = (sc == WIN);
      m_score = sc; m_lives = lv; m_time = tm;
      m_end = (ls || wn) ? 1 : 0;
      if (ls) begin
        m_state = 3; m_res = 1;
      end else if (wn) begin
        m_state = 2; m_res = 0;
      end
    end else begin
      m_end = 0;
      if (s) begin
        m_state = 1; m_score = 0; m_time = 0; m_presc = 0; m_lives = L;
      end
    end
  endtask

  task automatic step(input logic s, input logic p, input logic h);
    start = s; point = p; hit = h;
    model_cycle(s, p, h);
    sb.push_back(mexp());
    @(posedge vga_clk);
    #1;
    start = 1'b0; point = 1'b0; hit = 1'b0;
  endtask

  task automatic step2(input logic s, input logic p, input logic [1:0] est, input int esc);
    start2 = s; point2 = p;
    sb2.push_back({est, bcd(esc)});
    @(posedge vga_clk);
    #1;
    start2 = 1'b0; point2 = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    repeat (3) @(posedge vga_clk);
    #1;
    n_chk++;
    if (cur() !== 30'b0) $display("FAIL reset_dut got=%h exp=%h", cur(), 30'b0); else n_pass++;
    n_chk++;
    if ({state2, result2, score2, time2, lives2, end2} !== 30'b0)
      $display("FAIL reset_sat got=%h exp=0", {state2, result2, score2, time2, lives2, end2});
    else n_pass++;
    sys_rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_win();
    obs_t e;
    step(1'b1, 1'b0, 1'b0);
    e = sb.pop_front(); n_chk++;
    if (cur() !== e) $display("FAIL win_start got=%h exp=%h", cur(), e); else n_pass++;
    for (int i = 1; i <= 11; i++) begin
      step(1'b0, 1'b1, 1'b0);
      e = sb.pop_front(); n_chk++;
      if (cur() !== e) $display("FAIL win_point%0d got=%h exp=%h", i, cur(), e); else n_pass++;
    end
    n_chk++;
    if ({game_state, score_bcd} !== {S_PLAY, 12'h011})
      $display("FAIL win_at11 got=%h exp=%h", {game_state, score_bcd}, {S_PLAY, 12'h011});
    else n_pass++;
    step(1'b0, 1'b1, 1'b0);
    e = sb.pop_front(); n_chk++;
    if (cur() !== e) $display("FAIL win_point12 got=%h exp=%h", cur(), e); else n_pass++;
    n_chk++;
    if ({game_state, game_result, score_bcd, end_pulse} !== {S_WON, 1'b0, 12'h012, 1'b1})
      $display("FAIL win_final got=%h exp=%h", {game_state, game_result, score_bcd, end_pulse},
               {S_WON, 1'b0, 12'h012, 1'b1});
    else n_pass++;
    step(1'b0, 1'b0, 1'b0);
    e = sb.pop_front(); n_chk++;
    if (cur() !== e || end_pulse !== 1'b0) $display("FAIL win_pulse_drop got=%h exp=%h", cur(), e);
    else n_pass++;
  endtask

  task automatic test_lives();
    obs_t e;
    step(1'b1, 1'b0, 1'b0);
    e = sb.pop_front(); n_chk++;
    if (cur() !== e || lives !== 2'd3) $display("FAIL lives_start got=%h exp=%h", cur(), e); else n_pass++;
    for (int i = 1; i <= 3; i++) begin
      step(1'b0, 1'b0, 1'b1);
      e = sb.pop_front(); n_chk++;
      if (cur() !== e || lives !== 2'(3 - i))
        $display("FAIL lives_hit%0d got=%h exp=%h", i, cur(), e);
      else n_pass++;
    end
    n_chk++;
    if ({game_state, game_result, end_pulse} !== {S_LOST, 1'b1, 1'b1})
      $display("FAIL lives_lost got=%h exp=%h", {game_state, game_result, end_pulse}, {S_LOST, 1'b1, 1'b1});
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0);
      e = sb.pop_front(); n_chk++;
      if (cur() !== e || score_bcd !== 12'h000)
        $display("FAIL lives_frozen%0d got=%h exp=%h", i, cur(), e);
      else n_pass++;
    end
  endtask

  task automatic test_timeout();
    obs_t e;
    step(1'b1, 1'b0, 1'b0);
    e = sb.pop_front(); n_chk++;
    if (cur() !== e) $display("FAIL time_start got=%h exp=%h", cur(), e); else n_pass++;
    for (int i = 1; i <= 50; i++) begin
      step(1'b0, 1'b0, 1'b0);
      e = sb.pop_front(); n_chk++;
      if (cur() !== e) $display("FAIL time_cyc%0d got=%h exp=%h", i, cur(), e); else n_pass++;
      if (i % 10 == 0) begin
        n_chk++;
        if (time_bcd !== bcd(i / 10)) $display("FAIL time_step%0d got=%h exp=%h", i, time_bcd, bcd(i / 10));
        else n_pass++;
      end
    end
    n_chk++;
    if ({game_state, game_result, end_pulse} !== {S_LOST, 1'b1, 1'b1})
      $display("FAIL time_lost got=%h exp=%h", {game_state, game_result, end_pulse}, {S_LOST, 1'b1, 1'b1});
    else n_pass++;
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b0, 1'b0);
      e = sb.pop_front(); n_chk++;
      if (cur() !== e || time_bcd !== 12'h005) $display("FAIL time_hold%0d got=%h exp=%h", i, cur(), e);
      else n_pass++;
    end
  endtask

  task automatic test_simultaneous();
    obs_t e;
    step(1'b1, 1'b0, 1'b0);
    void'(sb.pop_front());
    for (int i = 0; i < 11; i++) begin
      step(1'b0, 1'b1, 1'b0);
      e = sb.pop_front(); n_chk++;
      if (cur() !== e) $display("FAIL sim_point%0d got=%h exp=%h", i, cur(), e); else n_pass++;
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 1'b1);
      e = sb.pop_front(); n_chk++;
      if (cur() !== e) $display("FAIL sim_hit%0d got=%h exp=%h", i, cur(), e); else n_pass++;
    end
    step(1'b0, 1'b1, 1'b1);
    e = sb.pop_front(); n_chk++;
    if (cur() !== e) $display("FAIL sim_both got=%h exp=%h", cur(), e); else n_pass++;
    n_chk++;
    if ({game_state, game_result, score_bcd, lives, end_pulse} !== {S_LOST, 1'b1, 12'h012, 2'd0, 1'b1})
      $display("FAIL sim_final got=%h exp=%h", {game_state, game_result, score_bcd, lives, end_pulse},
               {S_LOST, 1'b1, 12'h012, 2'd0, 1'b1});
    else n_pass++;
  endtask

  task automatic test_restart();
    obs_t e;
    step(1'b1, 1'b0, 1'b0);
    void'(sb.pop_front());
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, 1'b0);
      e = sb.pop_front(); n_chk++;
      if (cur() !== e) $display("FAIL rst_point%0d got=%h exp=%h", i, cur(), e); else n_pass++;
    end
    n_chk++;
    if (game_state !== S_WON) $display("FAIL rst_won got=%0d exp=%0d", game_state, S_WON); else n_pass++;
    step(1'b1, 1'b1, 1'b0);
    e = sb.pop_front(); n_chk++;
    if (cur() !== e) $display("FAIL rst_restart got=%h exp=%h", cur(), e); else n_pass++;
    n_chk++;
    if ({game_state, score_bcd, time_bcd, lives, end_pulse} !== {S_PLAY, 12'h000, 12'h000, 2'd3, 1'b0})
      $display("FAIL rst_clean got=%h exp=%h", {game_state, score_bcd, time_bcd, lives, end_pulse},
               {S_PLAY, 12'h000, 12'h000, 2'd3, 1'b0});
    else n_pass++;
    step(1'b0, 1'b1, 1'b0);
    e = sb.pop_front(); n_chk++;
    if (cur() !== e) $display("FAIL rst_first_point got=%h exp=%h", cur(), e); else n_pass++;
  endtask

  task automatic test_reset_midgame();
    obs_t e;
    step(1'b0, 1'b1, 1'b0);
    e = sb.pop_front(); n_chk++;
    if (cur() !== e || game_state !== S_PLAY) $display("FAIL mid_pre got=%h exp=%h", cur(), e);
    else n_pass++;
    #2;
    sys_rst_n = 1'b0;
    #1;
    n_chk++;
    if (cur() !== 30'b0) $display("FAIL mid_async got=%h exp=%h", cur(), 30'b0); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      @(posedge vga_clk);
      #1;
      n_chk++;
      if (cur() !== 30'b0 || end_pulse !== 1'b0) $display("FAIL mid_hold%0d got=%h exp=0", i, cur());
      else n_pass++;
    end
    sys_rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_saturation();
    logic [13:0] e2;
    step2(1'b1, 1'b0, S_PLAY, 0);
    e2 = sb2.pop_front(); n_chk++;
    if ({state2, score2} !== e2) $display("FAIL sat_start got=%h exp=%h", {state2, score2}, e2); else n_pass++;
    for (int i = 1; i <= 1000; i++) begin
      step2(1'b0, 1'b1, (i >= 999) ? S_WON : S_PLAY, (i < 999) ? i : 999);
      e2 = sb2.pop_front(); n_chk++;
      if ({state2, score2} !== e2) $display("FAIL sat_point%0d got=%h exp=%h", i, {state2, score2}, e2);
      else n_pass++;
      if (i == 999) begin
        n_chk++;
        if ({end2, result2, lives2, time2} !== {1'b1, 1'b0, 2'd3, 12'h099})
          $display("FAIL sat_win got=%h exp=%h", {end2, result2, lives2, time2}, {1'b1, 1'b0, 2'd3, 12'h099});
        else n_pass++;
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_win();
    test_lives();
    test_timeout();
    test_simultaneous();
    test_restart();
    test_reset_midgame();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
